// File: rtl/binary_search_ctrl_pkg.sv
// Shared types and verdict encoding for the successive-approximation search controller.
package binary_search_ctrl_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StProbe = 1'b1
    } state_e;

    // Verdict bits are packed as {less, greater, equal}.
    localparam logic [2:0] VerdictLess    = 3'b100;
    localparam logic [2:0] VerdictGreater = 3'b010;
    localparam logic [2:0] VerdictEqual   = 3'b001;

    function automatic logic verdict_is_one_hot(input logic [2:0] verdict);
        return (verdict == VerdictLess) || (verdict == VerdictGreater) ||
               (verdict == VerdictEqual);
    endfunction

endpackage

// File: rtl/binary_search_ctrl.sv
// Binary search over an N-bit value through an external magnitude comparator.
// One probe per transaction; lo/hi carry an extra bit so lo > hi is representable.
module binary_search_ctrl
    import binary_search_ctrl_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [N-1:0]             guess,
    output logic                     guess_valid,
    input  logic                     res_valid,
    input  logic                     res_less,
    input  logic                     res_greater,
    input  logic                     res_equal,
    output logic                     busy,
    output logic                     done,
    output logic                     found,
    output logic                     err,
    output logic [N-1:0]             result,
    output logic [$clog2(N+2)-1:0]   probes
);

    localparam int unsigned PW = $clog2(N + 2);
    localparam logic [N:0] MaxVal = {1'b0, {N{1'b1}}};

    state_e         state_q, state_d;
    logic [N:0]     lo_q, lo_d, hi_q, hi_d;
    logic [N:0]     mid;
    logic           found_q, found_d, err_q, err_d, done_q, done_d;
    logic [N-1:0]   result_q, result_d;
    logic [PW-1:0]  probes_q, probes_d;
    logic [2:0]     verdict;

    // Overflow-free midpoint: hi >= lo always holds while probing.
    assign mid     = lo_q + ((hi_q - lo_q) >> 1);
    assign verdict = {res_less, res_greater, res_equal};

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        found_d  = found_q;
        err_d    = err_q;
        result_d = result_q;
        probes_d = probes_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    lo_d     = '0;
                    hi_d     = MaxVal;
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                    result_d = '0;
                    probes_d = '0;
                    state_d  = StProbe;
                end
            end
            StProbe: begin
                if (res_valid) begin
                    probes_d = probes_q + 1'b1;
                    if (!verdict_is_one_hot(verdict)) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else if (res_equal) begin
                        found_d  = 1'b1;
                        result_d = mid[N-1:0];
                        done_d   = 1'b1;
                        state_d  = StIdle;
                    end else if (res_less) begin
                        if (mid == MaxVal) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            lo_d = mid + 1'b1;
                            if (lo_d > hi_q) begin
                                done_d  = 1'b1;
                                state_d = StIdle;
                            end
                        end
                    end else begin
                        if (mid == '0) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            hi_d = mid - 1'b1;
                            if (lo_q > hi_d) begin
                                done_d  = 1'b1;
                                state_d = StIdle;
                            end
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            lo_q     <= '0;
            hi_q     <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            probes_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            found_q  <= found_d;
            err_q    <= err_d;
            result_q <= result_d;
            probes_q <= probes_d;
            done_q   <= done_d;
        end
    end

    assign busy        = (state_q == StProbe);
    assign guess_valid = busy;
    assign guess       = busy ? mid[N-1:0] : '0;
    assign done        = done_q;
    assign found       = found_q;
    assign err         = err_q;
    assign result      = result_q;
    assign probes      = probes_q;

endmodule

// File: tb/tb_binary_search_ctrl.sv
// Bench for binary_search_ctrl: directed table, hand-written corner sequences and
// random targets checked against a plain-integer binary-search model.
module tb_binary_search_ctrl;

    localparam int unsigned N  = 8;
    localparam int unsigned PW = $clog2(N + 2);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  guess;
    logic          guess_valid;
    logic          res_valid;
    logic          res_less, res_greater, res_equal;
    logic          busy, done, found, err;
    logic [N-1:0]  result;
    logic [PW-1:0] probes;

    binary_search_ctrl #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .guess       (guess),
        .guess_valid (guess_valid),
        .res_valid   (res_valid),
        .res_less    (res_less),
        .res_greater (res_greater),
        .res_equal   (res_equal),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .err         (err),
        .result      (result),
        .probes      (probes)
    );

    always #5 clk = ~clk;

    // Responder: mode 0 compares against target, mode 1 always says less,
    // mode 2 returns the malformed {less, greater} pair. Verdict after 'delay' wait cycles.
    int unsigned target;
    int          delay;
    int          mode;
    int          wait_cnt;

    always_comb begin
        res_valid   = guess_valid && (wait_cnt >= delay);
        res_less    = 1'b0;
        res_greater = 1'b0;
        res_equal   = 1'b0;
        case (mode)
            0: begin
                res_less    = (int'(guess) < int'(target));
                res_greater = (int'(guess) > int'(target));
                res_equal   = (int'(guess) == int'(target));
            end
            1: res_less = 1'b1;
            default: begin
                res_less    = 1'b1;
                res_greater = 1'b1;
            end
        endcase
    end

    always @(posedge clk) begin
        if (!guess_valid || res_valid) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    int nvec  = 0;
    int nfail = 0;

    task automatic check(input string name, input logic [31:0] actual, input int expected);
        nvec++;
        if (actual !== expected) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // guess must not move while a probe is waiting for its verdict
    bit          prev_wait = 1'b0;
    logic [N-1:0] prev_guess = '0;
    always @(negedge clk) begin
        if (prev_wait && guess_valid && rst_n) check("guess_hold", guess, prev_guess);
        prev_wait  = guess_valid && !res_valid;
        prev_guess = guess;
    end

    int got_q[$];
    int exp_q[$];

    // Reference: textbook binary search on [0, 2^N-1] with integer bounds.
    task automatic model(input int tgt, input int md, output bit f, output bit e,
                         output int res, output int prb);
        int lo = 0;
        int hi = (1 << N) - 1;
        int g;
        f = 0; e = 0; res = 0; prb = 0;
        exp_q.delete();
        while (1) begin
            g = lo + (hi - lo) / 2;
            exp_q.push_back(g);
            prb++;
            if (md == 2) begin e = 1; return; end
            if (md == 0 && g == tgt) begin f = 1; res = g; return; end
            if (md == 1 || g < tgt) begin
                if (g == (1 << N) - 1) return;
                lo = g + 1;
            end else begin
                if (g == 0) return;
                hi = g - 1;
            end
            if (lo > hi) return;
        end
    endtask

    task automatic run_search(input int tgt, input int dly, input int md, input bit skip_start,
                              input bit poke_mid, input bit start_at_done, input string tag);
        bit done_seen = 0;
        bit f, e;
        int res, prb;
        target = tgt;
        delay  = dly;
        mode   = md;
        got_q.delete();
        if (!skip_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        check({tag, "_busy_at_start"}, busy, 1);
        check({tag, "_first_guess"}, guess, (1 << (N - 1)) - 1);
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                done_seen = 1;
                break;
            end
            if (guess_valid && res_valid) got_q.push_back(int'(guess));
            start = poke_mid && (i == 2);
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_done_seen"}, done_seen, 1);
        model(tgt, md, f, e, res, prb);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_gv_at_done"}, guess_valid, 0);
        check({tag, "_found"}, found, f);
        check({tag, "_err"}, err, e);
        check({tag, "_result"}, result, res);
        check({tag, "_probes"}, probes, prb);
        check({tag, "_nguesses"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_guess%0d", tag, i), (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
        if (start_at_done) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end else begin
            @(negedge clk);
            check({tag, "_done_one_cycle"}, done, 0);
        end
    endtask

    typedef struct {
        int tgt;
        int dly;
        int md;
        bit exp_found;
        bit exp_err;
        int exp_result;
        int exp_probes;
    } vec_t;

    vec_t tbl[5];
    int   g100[8];

    initial begin
        tbl[0] = '{tgt: 100, dly: 0, md: 0, exp_found: 1, exp_err: 0, exp_result: 100, exp_probes: 8};
        tbl[1] = '{tgt: 255, dly: 0, md: 0, exp_found: 1, exp_err: 0, exp_result: 255, exp_probes: 9};
        tbl[2] = '{tgt: 77,  dly: 0, md: 1, exp_found: 0, exp_err: 0, exp_result: 0,   exp_probes: 9};
        tbl[3] = '{tgt: 50,  dly: 0, md: 2, exp_found: 0, exp_err: 1, exp_result: 0,   exp_probes: 1};
        tbl[4] = '{tgt: 0,   dly: 3, md: 0, exp_found: 1, exp_err: 0, exp_result: 0,   exp_probes: 8};
        g100 = '{127, 63, 95, 111, 103, 99, 101, 100};

        rst_n = 1'b0;
        start = 1'b0;
        target = 0;
        delay = 0;
        mode = 0;
        repeat (3) @(negedge clk);
        check("rst_guess", guess, 0);
        check("rst_gv", guess_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 0);
        check("rst_probes", probes, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            run_search(tbl[k].tgt, tbl[k].dly, tbl[k].md, 0, 0, 0, $sformatf("tbl%0d", k));
            check($sformatf("tbl%0d_found_const", k), found, tbl[k].exp_found);
            check($sformatf("tbl%0d_err_const", k), err, tbl[k].exp_err);
            check($sformatf("tbl%0d_result_const", k), result, tbl[k].exp_result);
            check($sformatf("tbl%0d_probes_const", k), probes, tbl[k].exp_probes);
            if (k == 0)
                for (int i = 0; i < 8; i++)
                    check($sformatf("t100_guess%0d", i), (i < got_q.size()) ? got_q[i] : -1,
                          g100[i]);
        end

        // Reset during the 4th probe: immediate abort, no done pulse.
        target = 100;
        delay = 0;
        mode = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_probe4_guess", guess, 111);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_gv", guess_valid, 0);
        check("mid_rst_guess", guess, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_probes", probes, 0);
        check("mid_rst_found", found, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_no_done_after", done, 0);
        check("mid_rst_idle_after", busy, 0);

        // start while busy is ignored: the search must match an undisturbed one.
        run_search(100, 3, 0, 0, 1, 0, "poke");

        // start during the done cycle launches a new search.
        run_search(37, 0, 0, 0, 0, 1, "chain_a");
        check("chain_done_low", done, 0);
        run_search(200, 0, 0, 1, 0, 0, "chain_b");

        for (int r = 0; r < 20; r++)
            run_search($urandom_range(0, 255), $urandom_range(0, 2), 0, 0, 0, 0,
                       $sformatf("rnd%0d", r));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
